// File: rtl/vector_pkg.sv
// Shared constants and lane pack/unpack helpers for the vector lane control path.
//   INC_WIDTH / INC_NUMREGS / INC_LOG2NUMREGS : increment register file defaults
//   INC_MAXRD                                 : widest read-port count the helpers cover
//   lane_addr / lane_data / lane_put          : slice or update one lane of a packed bus
package vector_pkg;

    localparam int unsigned INC_WIDTH       = 32;
    localparam int unsigned INC_NUMREGS     = 8;
    localparam int unsigned INC_LOG2NUMREGS = 3;
    localparam int unsigned INC_MAXRD       = 4;

    localparam int unsigned INC_ABUS_W = INC_MAXRD * INC_LOG2NUMREGS;
    localparam int unsigned INC_DBUS_W = INC_MAXRD * INC_WIDTH;

    // Read address of one lane from a packed address bus.
    function automatic logic [INC_LOG2NUMREGS-1:0] lane_addr(
        input logic [INC_ABUS_W-1:0] bus,
        input int unsigned           lane
    );
        return bus[lane*INC_LOG2NUMREGS +: INC_LOG2NUMREGS];
    endfunction

    // Data of one lane from a packed data bus.
    function automatic logic [INC_WIDTH-1:0] lane_data(
        input logic [INC_DBUS_W-1:0] bus,
        input int unsigned           lane
    );
        return bus[lane*INC_WIDTH +: INC_WIDTH];
    endfunction

    // Replace one lane of a packed data bus.
    function automatic logic [INC_DBUS_W-1:0] lane_put(
        input logic [INC_DBUS_W-1:0] bus,
        input int unsigned           lane,
        input logic [INC_WIDTH-1:0]  data
    );
        logic [INC_DBUS_W-1:0] r;
        r = bus;
        r[lane*INC_WIDTH +: INC_WIDTH] = data;
        return r;
    endfunction

endpackage

// File: rtl/vregfile_inc_rdport.sv
// One registered read port of the increment register file.
//   clk, reset : clock and async active-high reset (clears the output lane)
//   i_en       : read enable; when low the lane holds its previous value
//   i_reg      : read address
//   i_cur      : pre-edge register view (entry 0 is constant zero)
//   i_nxt      : value each register will hold after this edge
//   o_data     : registered read data
module vregfile_inc_rdport #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned NUMREGS     = 8,
    parameter int unsigned LOG2NUMREGS = 3,
    parameter int unsigned BYPASS      = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_en,
    input  logic [LOG2NUMREGS-1:0] i_reg,
    input  logic [WIDTH-1:0]       i_cur [NUMREGS],
    input  logic [WIDTH-1:0]       i_nxt [NUMREGS],
    output logic [WIDTH-1:0]       o_data
);

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_sel;

    // i_nxt only differs from i_cur for registers written this cycle, so picking
    // it is the bypass: a same-cycle write shows through, anything else reads as stored.
    always_comb begin
        w_sel = i_cur[i_reg];
        if (BYPASS != 0) begin
            w_sel = i_nxt[i_reg];
        end
    end

    // Output lane register, holding while the port is idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else if (i_en) begin
            r_data <= w_sel;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/vregfile_inc_mp.sv
// Multi-port vector increment register file (stride registers for address generation).
//   clk, reset     : clock and async active-high reset (clears all registers and lanes)
//   a_en/a_reg     : per-port read enable and packed read addresses
//   a_readdataout  : packed registered read data, 1-cycle latency
//   c_we/c_reg/c_writedatain : plain write port
//   d_en/d_reg/d_delta       : post-increment port (reg += delta, wraps)
// Register 0 reads as zero and ignores writes; c beats d on the same register.
module vregfile_inc_mp
    import vector_pkg::*;
#(
    parameter int unsigned WIDTH       = INC_WIDTH,
    parameter int unsigned NUMREGS     = INC_NUMREGS,
    parameter int unsigned LOG2NUMREGS = INC_LOG2NUMREGS,
    parameter int unsigned NUMRD       = 2,
    parameter int unsigned BYPASS      = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUMRD-1:0]             a_en,
    input  logic [NUMRD*LOG2NUMREGS-1:0] a_reg,
    output logic [NUMRD*WIDTH-1:0]       a_readdataout,
    input  logic                         c_we,
    input  logic [LOG2NUMREGS-1:0]       c_reg,
    input  logic [WIDTH-1:0]             c_writedatain,
    input  logic                         d_en,
    input  logic [LOG2NUMREGS-1:0]       d_reg,
    input  logic [WIDTH-1:0]             d_delta
);

    logic [WIDTH-1:0] r_regs [NUMREGS-1:1];
    logic [WIDTH-1:0] w_cur  [NUMREGS];
    logic [WIDTH-1:0] w_nxt  [NUMREGS];
    logic [NUMREGS-1:0] w_wr;
    logic [WIDTH-1:0] w_d_sum;

    // Commit priority for one register: plain write, else increment, else keep.
    function automatic logic [WIDTH-1:0] next_val(
        input logic [WIDTH-1:0] cur,
        input logic             c_hit,
        input logic             d_hit,
        input logic [WIDTH-1:0] c_data,
        input logic [WIDTH-1:0] d_sum
    );
        if (c_hit) begin
            return c_data;
        end else if (d_hit) begin
            return d_sum;
        end
        return cur;
    endfunction

    // Pre-edge view with the constant-zero register 0 in front.
    always_comb begin
        w_cur[0] = '0;
        for (int unsigned k = 1; k < NUMREGS; k++) begin
            w_cur[k] = r_regs[k];
        end
    end

    // Single adder; d_reg==0 yields no write below, so its sum is never committed.
    assign w_d_sum = w_cur[d_reg] + d_delta;

    // Next value and write strobe per register; the same result feeds storage and bypass.
    always_comb begin
        w_nxt[0] = '0;
        w_wr     = '0;
        for (int unsigned k = 1; k < NUMREGS; k++) begin
            w_wr[k]  = (c_we && (c_reg == LOG2NUMREGS'(k))) ||
                       (d_en && (d_reg == LOG2NUMREGS'(k)));
            w_nxt[k] = next_val(w_cur[k],
                                c_we && (c_reg == LOG2NUMREGS'(k)),
                                d_en && (d_reg == LOG2NUMREGS'(k)),
                                c_writedatain, w_d_sum);
        end
    end

    // Register storage for entries 1..NUMREGS-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 1; k < NUMREGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int unsigned k = 1; k < NUMREGS; k++) begin
                if (w_wr[k]) begin
                    r_regs[k] <= w_nxt[k];
                end
            end
        end
    end

    // One independent read port per lane.
    for (genvar g = 0; g < NUMRD; g++) begin : g_rd
        vregfile_inc_rdport #(
            .WIDTH       (WIDTH),
            .NUMREGS     (NUMREGS),
            .LOG2NUMREGS (LOG2NUMREGS),
            .BYPASS      (BYPASS)
        ) u_rdport (
            .clk    (clk),
            .reset  (reset),
            .i_en   (a_en[g]),
            .i_reg  (a_reg[g*LOG2NUMREGS +: LOG2NUMREGS]),
            .i_cur  (w_cur),
            .i_nxt  (w_nxt),
            .o_data (a_readdataout[g*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_vregfile_inc_mp.sv
// Scoreboard bench: two instances (BYPASS=0 and BYPASS=1) share all stimulus.
// Each read pushes the expected old/new lane value; the monitor pops and compares.
module tb_vregfile_inc_mp;
    import vector_pkg::*;

    logic        clk;
    logic        reset;
    logic [1:0]  a_en;
    logic [5:0]  a_reg;
    logic [63:0] rd0;
    logic [63:0] rd1;
    logic        c_we;
    logic [2:0]  c_reg;
    logic [31:0] c_writedatain;
    logic        d_en;
    logic [2:0]  d_reg;
    logic [31:0] d_delta;

    typedef struct packed {
        logic [31:0] e0;
        logic [31:0] e1;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] m [8];
    logic        done;
    int          n_vec;
    int          n_miss;

    vregfile_inc_mp #(.NUMRD(2), .BYPASS(0)) u_dut0 (
        .clk(clk), .reset(reset), .a_en(a_en), .a_reg(a_reg), .a_readdataout(rd0),
        .c_we(c_we), .c_reg(c_reg), .c_writedatain(c_writedatain),
        .d_en(d_en), .d_reg(d_reg), .d_delta(d_delta)
    );

    vregfile_inc_mp #(.NUMRD(2), .BYPASS(1)) u_dut1 (
        .clk(clk), .reset(reset), .a_en(a_en), .a_reg(a_reg), .a_readdataout(rd1),
        .c_we(c_we), .c_reg(c_reg), .c_writedatain(c_writedatain),
        .d_en(d_en), .d_reg(d_reg), .d_delta(d_delta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, predict what each enabled lane must show after the edge.
    task automatic step(input logic rst, input logic [1:0] en,
                        input logic [2:0] r0, input logic [2:0] r1,
                        input logic cwe, input logic [2:0] creg, input logic [31:0] cdat,
                        input logic den, input logic [2:0] dreg, input logic [31:0] ddel);
        logic [31:0] nxt [8];
        reset = rst; a_en = en; a_reg = {r1, r0};
        c_we = cwe; c_reg = creg; c_writedatain = cdat;
        d_en = den; d_reg = dreg; d_delta = ddel;
        for (int k = 0; k < 8; k++) nxt[k] = m[k];
        if (den && dreg != 3'd0) nxt[dreg] = m[dreg] + ddel;
        if (cwe && creg != 3'd0) nxt[creg] = cdat;
        if (rst) begin
            for (int k = 0; k < 8; k++) m[k] = 32'd0;
        end else begin
            if (en[0]) q0.push_back('{e0: m[r0], e1: nxt[r0]});
            if (en[1]) q1.push_back('{e0: m[r1], e1: nxt[r1]});
            for (int k = 0; k < 8; k++) m[k] = nxt[k];
        end
        @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] en, input logic [2:0] r0, input logic [2:0] r1);
        step(1'b0, en, r0, r1, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic wc(input logic [2:0] creg, input logic [31:0] cdat);
        step(1'b0, 2'b00, 3'd0, 3'd0, 1'b1, creg, cdat, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic wd(input logic [2:0] dreg, input logic [31:0] ddel);
        step(1'b0, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b1, dreg, ddel);
    endtask

    initial begin : stim
        done = 1'b0;
        reset = 1'b1; a_en = '0; a_reg = '0;
        c_we = 1'b0; c_reg = '0; c_writedatain = '0;
        d_en = 1'b0; d_reg = '0; d_delta = '0;
        for (int k = 0; k < 8; k++) m[k] = 32'd0;
        @(negedge clk);
        // 1: write during reset is lost; everything reads 0, then a real write
        step(1'b1, 2'b11, 3'd3, 3'd3, 1'b1, 3'd3, 32'h10, 1'b0, 3'd0, 32'd0);
        step(1'b1, 2'b00, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
        for (int k = 0; k < 8; k += 2) rd(2'b11, 3'(k), 3'(k + 1));
        wc(3'd3, 32'h10);
        rd(2'b11, 3'd3, 3'd0);
        // 2: register 0 ignores c and d
        wc(3'd0, 32'hFFFF);
        rd(2'b11, 3'd0, 3'd3);
        wd(3'd0, 32'd5);
        rd(2'b01, 3'd0, 3'd0);
        // 3: three back-to-back decrements, then wrap
        wc(3'd2, 32'd100);
        wd(3'd2, 32'hFFFF_FFFD);
        wd(3'd2, 32'hFFFF_FFFD);
        wd(3'd2, 32'hFFFF_FFFD);
        rd(2'b11, 3'd2, 3'd2);
        wc(3'd7, 32'hFFFF_FFFF);
        wd(3'd7, 32'd1);
        rd(2'b10, 3'd0, 3'd7);
        // 4: collision c wins; different targets both commit (read in the same cycle)
        step(1'b0, 2'b00, 3'd0, 3'd0, 1'b1, 3'd4, 32'd7, 1'b1, 3'd4, 32'd2);
        rd(2'b01, 3'd4, 3'd0);
        wc(3'd4, 32'd0);
        wc(3'd5, 32'd1);
        step(1'b0, 2'b11, 3'd4, 3'd5, 1'b1, 3'd4, 32'd7, 1'b1, 3'd5, 32'd2);
        rd(2'b11, 3'd4, 3'd5);
        // 5: read during write, old vs new by build, then settled
        wc(3'd6, 32'd1);
        step(1'b0, 2'b01, 3'd6, 3'd0, 1'b1, 3'd6, 32'd9, 1'b0, 3'd0, 32'd0);
        rd(2'b11, 3'd6, 3'd6);
        // 6: port0 holds while port1 tracks increments of reg1
        wc(3'd1, 32'h55);
        rd(2'b11, 3'd1, 3'd1);
        for (int k = 0; k < 4; k++)
            step(1'b0, 2'b10, 3'd1, 3'd1, 1'b0, 3'd0, 32'd0, 1'b1, 3'd1, 32'd1);
        rd(2'b11, 3'd1, 3'd1);
        // reset mid-operation drops the pending write
        step(1'b1, 2'b11, 3'd1, 3'd3, 1'b1, 3'd3, 32'hABCD, 1'b0, 3'd0, 32'd0);
        rd(2'b11, 3'd1, 3'd3);
        rd(2'b00, 3'd0, 3'd0);
        rd(2'b00, 3'd0, 3'd0);
        done = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    initial begin : monitor
        logic [1:0]  en_s;
        logic        rst_s;
        exp_t        last [2];
        exp_t        e;
        logic [31:0] g0;
        logic [31:0] g1;
        bit          have;
        n_vec = 0;
        n_miss = 0;
        last[0] = '0;
        last[1] = '0;
        while (!done) begin
            @(posedge clk);
            en_s  = a_en;
            rst_s = reset;
            @(negedge clk);
            for (int l = 0; l < 2; l++) begin
                have = 1'b1;
                if (rst_s) begin
                    e = '0;
                    last[l] = e;
                end else if (en_s[l]) begin
                    if (l == 0 && q0.size() > 0) e = q0.pop_front();
                    else if (l == 1 && q1.size() > 0) e = q1.pop_front();
                    else begin
                        have = 1'b0;
                        n_vec++;
                        n_miss++;
                        $display("FAIL lane%0d: read presented with no expected entry", l);
                    end
                    if (have) last[l] = e;
                end else begin
                    e = last[l];
                end
                if (have) begin
                    g0 = lane_data(INC_DBUS_W'(rd0), l);
                    g1 = lane_data(INC_DBUS_W'(rd1), l);
                    chk($sformatf("lane%0d bypass0 t=%0t", l, $time), g0, e.e0);
                    chk($sformatf("lane%0d bypass1 t=%0t", l, $time), g1, e.e1);
                end
            end
        end
        chk("lane0 leftover expectations", 32'(q0.size()), 32'd0);
        chk("lane1 leftover expectations", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
